btf: RTL and testbench



---
 rtl/btf.sv | 114 +++++++++++
 tb/tb_btf.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/btf.sv
// -----------------------------------------------------------------------------
// btf -- radix-2 decimation-in-time butterfly, two-stage pipeline.
//
// Computes, for every clock cycle's operand set:
//   dout1 = x1 + x2*wn
//   dout2 = x1 - x2*wn
//
// Ports
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous reset, ACTIVE-HIGH (1 = in reset) despite the name
//   din1   in  64   x1 = {imag[63:32], real[31:0]}, signed 32-bit parts
//   din2   in  64   x2, same packing as din1
//   wn     in  32   twiddle = {imag[31:16], real[15:0]}, signed Q1.14 parts
//   dout1  out 64   registered x1 + x2*wn, same packing as din1
//   dout2  out 64   registered x1 - x2*wn, same packing as din1
//
// Pipeline
//   stage 1: four 32x16 signed partial products, x1 delayed alongside them
//   stage 2: complex sum at 49 bits, arithmetic >>14 (floor), low 32 bits,
//            wrap-around add/subtract into the output registers
// -----------------------------------------------------------------------------
module btf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] din1,
  input  logic [63:0] din2,
  input  logic [31:0] wn,
  output logic [63:0] dout1,
  output logic [63:0] dout2
);

  // ---------------------------------------------------------------------------
  // Operand unpacking, sign-extended to the 48-bit product width
  // ---------------------------------------------------------------------------
  logic signed [47:0] x2r_ext;
  logic signed [47:0] x2i_ext;
  logic signed [47:0] wr_ext;
  logic signed [47:0] wi_ext;

  assign x2r_ext = {{16{din2[31]}}, din2[31:0]};
  assign x2i_ext = {{16{din2[63]}}, din2[63:32]};
  assign wr_ext  = {{32{wn[15]}}, wn[15:0]};
  assign wi_ext  = {{32{wn[31]}}, wn[31:16]};

  // ---------------------------------------------------------------------------
  // Stage 1: partial products and the aligned copy of x1
  // ---------------------------------------------------------------------------
  logic signed [47:0] p_rr_reg;   // x2r * wr
  logic signed [47:0] p_ii_reg;   // x2i * wi
  logic signed [47:0] p_ri_reg;   // x2r * wi
  logic signed [47:0] p_ir_reg;   // x2i * wr
  logic        [63:0] x1_reg;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      p_rr_reg <= '0;
      p_ii_reg <= '0;
      p_ri_reg <= '0;
      p_ir_reg <= '0;
      x1_reg   <= '0;
    end else begin
      // |32-bit| * |16-bit| never exceeds 2^46, so the 48-bit product is exact,
      // including the wr = -32768 corner.
      p_rr_reg <= x2r_ext * wr_ext;
      p_ii_reg <= x2i_ext * wi_ext;
      p_ri_reg <= x2r_ext * wi_ext;
      p_ir_reg <= x2i_ext * wr_ext;
      x1_reg   <= din1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational part: full-precision complex product and scaling
  // ---------------------------------------------------------------------------
  logic signed [48:0] pr_full;
  logic signed [48:0] pi_full;

  // One extra bit so that e.g. (-2^31)(-2^15) - (2^31-1)(-2^15) does not overflow.
  assign pr_full = {p_rr_reg[47], p_rr_reg} - {p_ii_reg[47], p_ii_reg};
  assign pi_full = {p_ri_reg[47], p_ri_reg} + {p_ir_reg[47], p_ir_reg};

  // t_lane[0] = tr, t_lane[1] = ti. The arithmetic shift floors toward minus
  // infinity; the size cast keeps only the low 32 bits of the scaled value.
  logic [31:0] t_lane [2];

  assign t_lane[0] = 32'(pr_full >>> 14);
  assign t_lane[1] = 32'(pi_full >>> 14);

  // ---------------------------------------------------------------------------
  // Stage 2 registers: one identical lane each for real (0) and imag (1)
  // ---------------------------------------------------------------------------
  logic [31:0] sum_reg [2];
  logic [31:0] dif_reg [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
          sum_reg[gi] <= '0;
          dif_reg[gi] <= '0;
        end else begin
          // Plain 32-bit modular arithmetic: overflow wraps, no saturation.
          sum_reg[gi] <= x1_reg[32*gi +: 32] + t_lane[gi];
          dif_reg[gi] <= x1_reg[32*gi +: 32] - t_lane[gi];
        end
      end
    end
  endgenerate

  assign dout1 = {sum_reg[1], sum_reg[0]};
  assign dout2 = {dif_reg[1], dif_reg[0]};

endmodule

// File: tb/tb_btf.sv
// -----------------------------------------------------------------------------
// tb_btf -- self-checking bench for btf.
//
// The driver applies one operand set per cycle on the falling edge and pushes
// the hand-computed result, tagged with the cycle it is due, into a scoreboard
// queue. A separate monitor pops and compares on every falling edge, so every
// output cycle (including zero outputs around reset) is checked.
// -----------------------------------------------------------------------------
module tb_btf;

  logic        clk;
  logic        rst_n;
  logic [63:0] din1;
  logic [63:0] din2;
  logic [31:0] wn;
  logic [63:0] dout1;
  logic [63:0] dout2;

  btf dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din1  (din1),
    .din2  (din2),
    .wn    (wn),
    .dout1 (dout1),
    .dout2 (dout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [63:0] e1;
    logic [63:0] e2;
    string       nm;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  function automatic logic [63:0] cx(input int re, input int im);
    return {im, re};
  endfunction

  function automatic logic [31:0] tw(input shortint re, input shortint im);
    return {im, re};
  endfunction

  task automatic chk(input string nm, input logic [63:0] a1, input logic [63:0] a2,
                     input logic [63:0] x1, input logic [63:0] x2);
    checks++;
    if (a1 !== x1 || a2 !== x2) begin
      errors++;
      $display("FAIL %s @cyc %0d: dout1=%h dout2=%h expected dout1=%h dout2=%h",
               nm, cyc, a1, a2, x1, x2);
    end else begin
      $display("ok   %s @cyc %0d: dout1=%h dout2=%h", nm, cyc, a1, a2);
    end
  endtask

  // Monitor: compare whatever is due this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: result due at cyc %0d never compared (now %0d)", e.nm, e.due, cyc);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk(e.nm, dout1, dout2, e.e1, e.e2);
    end
  end

  // Apply one operand set on the next falling edge; optionally release reset
  // at that same moment. Sampled on the following rising edge, the result is
  // on the outputs after the rising edge after that.
  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [31:0] w,
                       input logic [63:0] x1, input logic [63:0] x2,
                       input string nm, input bit rel);
    exp_t e;
    @(negedge clk);
    if (rel) rst_n = 1'b0;
    din1 = a;
    din2 = b;
    wn   = w;
    e.due = cyc + 2;
    e.e1  = x1;
    e.e2  = x2;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(64'd0, 64'd0, 32'd0, 64'd0, 64'd0, "idle", 1'b0);
  endtask

  int bound;

  initial begin
    din1  = '0;
    din2  = '0;
    wn    = '0;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #1 chk("reset_async", dout1, dout2, 64'd0, 64'd0);

    // Garbage while in reset must be ignored.
    drive(cx(11, 22), cx(33, 44), tw(16384, 0), 64'd0, 64'd0, "in_reset_a", 1'b0);
    drive(cx(55, 66), cx(77, 88), tw(0, 16384), 64'd0, 64'd0, "in_reset_b", 1'b0);

    // Release together with the first vector: unity twiddle.
    drive(cx(500, 0), cx(0, -500), tw(16384, 0),
          cx(500, -500), cx(500, 500), "unity", 1'b1);
    idle(2);

    // Back-to-back: unity, -j, W8^1 with floor.
    drive(cx(500, 0), cx(0, -500), tw(16384, 0),
          cx(500, -500), cx(500, 500), "pipe_unity", 1'b0);
    drive(cx(10, 20), cx(300, 100), tw(0, -16384),
          cx(110, -280), cx(-90, 320), "pipe_minus_j", 1'b0);
    drive(cx(0, 0), cx(1000, 0), tw(11584, -11584),
          cx(707, -708), cx(-707, 708), "pipe_w8_floor", 1'b0);
    idle(2);

    // Wrap-around, wr = -2.0, and full-range corners.
    drive(cx(int'(32'h7FFFFFFF), 0), cx(1, 0), tw(16384, 0),
          cx(int'(32'h80000000), 0), cx(int'(32'h7FFFFFFE), 0), "wrap", 1'b0);
    drive(cx(100, 200), cx(3, 5), tw(-32768, 0),
          cx(94, 190), cx(106, 210), "wr_minus2", 1'b0);
    drive(cx(5, 7), cx(int'(32'h80000000), 0), tw(-32768, 16384),
          cx(5, int'(32'h80000007)), cx(5, int'(32'h80000007)), "big_prod", 1'b0);
    drive(cx(0, 0), cx(int'(32'h80000000), int'(32'h7FFFFFFF)), tw(-32768, -32768),
          cx(-2, 2), cx(2, -2), "sum49", 1'b0);
    idle(2);

    // Mid-stream reset with the pipeline full.
    drive(cx(10, 20), cx(300, 100), tw(0, -16384),
          cx(110, -280), cx(-90, 320), "pre_rst_a", 1'b0);
    drive(cx(0, 0), cx(1000, 0), tw(11584, -11584),
          cx(707, -708), cx(-707, 708), "pre_rst_b", 1'b0);
    drive(cx(500, 0), cx(0, -500), tw(16384, 0),
          cx(500, -500), cx(500, 500), "pre_rst_c", 1'b0);
    #2 rst_n = 1'b1;
    sb.delete();
    #1 chk("midrst_async", dout1, dout2, 64'd0, 64'd0);
    drive(cx(9, 9), cx(9, 9), tw(16384, 16384), 64'd0, 64'd0, "midrst_hold_a", 1'b0);
    drive(cx(8, 8), cx(8, 8), tw(16384, 16384), 64'd0, 64'd0, "midrst_hold_b", 1'b0);
    drive(cx(7, 7), cx(7, 7), tw(16384, 16384), 64'd0, 64'd0, "midrst_hold_c", 1'b0);
    drive(cx(10, 20), cx(300, 100), tw(0, -16384),
          cx(110, -280), cx(-90, 320), "post_rst", 1'b1);
    idle(3);

    // Drain with a bounded wait.
    bound = 0;
    while (sb.size() > 0 && bound < 10) begin
      @(negedge clk);
      bound++;
    end
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
